pe_acc_pipe: RTL and testbench

//  Parametrised next-generation systolic processing element with valid-qualified data flow.

---
 rtl/pe_acc_pipe.sv | 136 +++++++++++++
 tb/tb_pe_acc_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_pipe.sv
// Systolic PE: 1-cycle operand/control forwarding plus a two-stage CONV/MAXPOOL/SUM window accumulator.
// Optional macro PE_SATURATE_EN clamps psum_o to the DATA_WIDTH signed range instead of wrapping.
module pe_acc_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int GUARD_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode_i,
    input  logic                  vld_i,
    input  logic                  clr_i,
    input  logic                  last_i,
    input  logic [DATA_WIDTH-1:0] srca_i,
    input  logic [DATA_WIDTH-1:0] srcb_i,
    output logic                  vld_o,
    output logic                  clr_o,
    output logic                  last_o,
    output logic [1:0]            mode_o,
    output logic [DATA_WIDTH-1:0] srca_o,
    output logic [DATA_WIDTH-1:0] srcb_o,
    output logic [DATA_WIDTH-1:0] psum_o,
    output logic                  psum_vld_o
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_SUM = 2'b10;

    function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [ACC_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] sh;
`ifdef PE_SATURATE_EN
        logic signed [ACC_WIDTH-1:0] sat_max;
        logic signed [ACC_WIDTH-1:0] sat_min;
        sat_max = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        sat_min = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        sh = x >>> FRAC_BITS;
        if (sh > sat_max)
            sh = sat_max;
        else if (sh < sat_min)
            sh = sat_min;
`else
        sh = x >>> FRAC_BITS;
`endif
        return DATA_WIDTH'(sh);
    endfunction

    logic signed [DATA_WIDTH-1:0]   a_s;
    logic signed [DATA_WIDTH-1:0]   b_s;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    p_nxt;
    logic [1:0]                     mode_eff;

    logic [1:0]                     win_mode_p1;
    logic signed [ACC_WIDTH-1:0]    p_p1;
    logic                           vld_p1;
    logic                           clr_p1;
    logic                           last_p1;
    logic                           max_p1;

    logic signed [ACC_WIDTH-1:0]    acc_p2;
    logic signed [ACC_WIDTH-1:0]    acc_nxt;

    assign a_s  = srca_i;
    assign b_s  = srcb_i;
    assign prod = (2*DATA_WIDTH)'(a_s) * (2*DATA_WIDTH)'(b_s);

    // The window's mode takes effect on its clr element itself, then sticks until the next clr.
    always_comb begin
        mode_eff = clr_i ? mode_i : win_mode_p1;
        if (mode_eff == MODE_MAX || mode_eff == MODE_SUM)
            p_nxt = ACC_WIDTH'(a_s) <<< FRAC_BITS;
        else
            p_nxt = ACC_WIDTH'(prod);
    end

    // Stage 0 -> 1: forwarding registers and operand pre-scaling
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_o       <= 1'b0;
            clr_o       <= 1'b0;
            last_o      <= 1'b0;
            mode_o      <= '0;
            srca_o      <= '0;
            srcb_o      <= '0;
            win_mode_p1 <= '0;
            p_p1        <= '0;
            vld_p1      <= 1'b0;
            clr_p1      <= 1'b0;
            last_p1     <= 1'b0;
            max_p1      <= 1'b0;
        end else begin
            vld_o  <= vld_i;
            clr_o  <= clr_i;
            last_o <= last_i;
            mode_o <= mode_i;
            srca_o <= srca_i;
            srcb_o <= srcb_i;
            vld_p1 <= vld_i;
            if (vld_i) begin
                p_p1    <= p_nxt;
                clr_p1  <= clr_i;
                last_p1 <= last_i;
                max_p1  <= (mode_eff == MODE_MAX);
                if (clr_i)
                    win_mode_p1 <= mode_i;
            end
        end
    end

    always_comb begin
        if (clr_p1)
            acc_nxt = p_p1;
        else if (max_p1)
            acc_nxt = (p_p1 > acc_p2) ? p_p1 : acc_p2;
        else
            acc_nxt = acc_p2 + p_p1;
    end

    // Stage 1 -> 2: accumulate and emit the window result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_p2     <= '0;
            psum_o     <= '0;
            psum_vld_o <= 1'b0;
        end else begin
            psum_vld_o <= vld_p1 & last_p1;
            if (vld_p1) begin
                acc_p2 <= acc_nxt;
                if (last_p1)
                    psum_o <= scale(acc_nxt);
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_pipe.sv
// Scoreboard bench for pe_acc_pipe: expected window results are queued with their due cycle.
module tb_pe_acc_pipe;

    localparam logic [1:0] CONV = 2'b00;
    localparam logic [1:0] MAXP = 2'b01;
    localparam logic [1:0] SUMM = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        vld, clr, last;
    logic [15:0] srca, srcb;
    logic        fwd_vld, fwd_clr, fwd_last;
    logic [1:0]  fwd_mode;
    logic [15:0] fwd_srca, fwd_srcb;
    logic [15:0] psum;
    logic        psum_vld;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    pe_acc_pipe #(.DATA_WIDTH(16), .FRAC_BITS(8), .GUARD_BITS(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .vld_i(vld), .clr_i(clr), .last_i(last),
        .srca_i(srca), .srcb_i(srcb), .vld_o(fwd_vld), .clr_o(fwd_clr), .last_o(fwd_last),
        .mode_o(fwd_mode), .srca_o(fwd_srca), .srcb_o(fwd_srcb), .psum_o(psum), .psum_vld_o(psum_vld)
    );

    // One clock; at the following falling edge pop and compare any result pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (psum_vld) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL spurious_pulse cyc=%0d psum=%h, no result expected", cyc, psum);
            end else begin
                e = sbq.pop_front();
                if (psum !== e.val || cyc != e.due) begin
                    failures++;
                    $display("FAIL psum got=%h at cyc %0d, expected=%h at cyc %0d", psum, cyc, e.val, e.due);
                end
            end
        end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse cyc=%0d got no pulse, expected psum=%h", cyc, e.val);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic l, input logic [1:0] m,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] ex);
        vld = v; clr = c; last = l; mode = m; srca = a; srcb = b;
        tick();
        checks++;
        if ({fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb} !== {v, c, l, m, a, b}) begin
            failures++;
            $display("FAIL forward got=%b_%b_%b_%b_%h_%h expected=%b_%b_%b_%b_%h_%h",
                     fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, v, c, l, m, a, b);
        end
        if (v && l)
            sbq.push_back('{ex, cyc + 1});
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bubble();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = 1'b1; clr = 1'b1; last = 1'b1; mode = SUMM; srca = 16'h1234; srcb = 16'h5678;
        #1;
        checks++;
        if ({fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld} !== 54'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld});
        end
        tick();
        tick();
        checks++;
        if ({fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld} !== 54'h0) begin
            failures++;
            $display("FAIL reset_held got=%h expected=0",
                     {fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld});
        end
        vld = 1'b0; clr = 1'b0; last = 1'b0; mode = CONV;
        rst_n = 1'b1;
        tick();
    endtask

    // Element with no preceding clr combines with the zero accumulator in CONV mode.
    task automatic test_no_clr();
        drive(1, 0, 1, SUMM, 16'h0100, 16'h0200, 16'h0200);
        idle(2);
    endtask

    task automatic test_conv();
        drive(1, 1, 0, CONV, 16'h0180, 16'h0200, 16'h0);
        drive(1, 0, 0, CONV, 16'h0100, 16'h0100, 16'h0);
        drive(1, 0, 1, CONV, 16'hFF00, 16'h0100, 16'h0300);
        idle(3);
    endtask

    task automatic test_maxpool();
        drive(1, 1, 0, MAXP, 16'hFF00, 16'h7FFF, 16'h0);
        drive(1, 0, 0, CONV, 16'h0280, 16'h8000, 16'h0);
        drive(1, 0, 1, SUMM, 16'h0100, 16'h1234, 16'h0280);
        idle(3);
    endtask

    task automatic test_bubbles();
        drive(1, 1, 0, CONV, 16'h0180, 16'h0200, 16'h0);
        bubble();
        drive(1, 0, 0, CONV, 16'h0100, 16'h0100, 16'h0);
        bubble();
        bubble();
        drive(1, 0, 1, CONV, 16'hFF00, 16'h0100, 16'h0300);
        idle(3);
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, SUMM, 16'h0100, 16'h5555, 16'h0);
        drive(1, 0, 1, SUMM, 16'h0100, 16'hAAAA, 16'h0200);
        drive(1, 1, 1, CONV, 16'h0200, 16'h0200, 16'h0400);
        // An unterminated CONV window is abandoned by the following clr.
        drive(1, 1, 0, CONV, 16'h0100, 16'h0100, 16'h0);
        drive(1, 1, 0, SUMM, 16'h0300, 16'h0700, 16'h0);
        drive(1, 0, 1, CONV, 16'h0100, 16'h0700, 16'h0400);
        idle(3);
    endtask

    task automatic test_saturate();
        logic [15:0] ex;
`ifdef PE_SATURATE_EN
        ex = 16'h7FFF;
`else
        ex = 16'h0200;
`endif
        drive(1, 1, 0, CONV, 16'h7F00, 16'h7F00, 16'h0);
        drive(1, 0, 1, CONV, 16'h7F00, 16'h7F00, ex);
        idle(3);
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        drive(1, 1, 0, SUMM, 16'h0100, 16'h0100, 16'h0);
        drive(1, 0, 1, SUMM, 16'h0200, 16'h0200, 16'h0);
        dropped = sbq.pop_back();
        vld = 1'b0; clr = 1'b0; last = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld} !== 54'h0) begin
            failures++;
            $display("FAIL reset_mid got=%h expected=0",
                     {fwd_vld, fwd_clr, fwd_last, fwd_mode, fwd_srca, fwd_srcb, psum, psum_vld});
        end
        tick();
        rst_n = 1'b1;
        idle(2);
        drive(1, 1, 1, CONV, 16'h0100, 16'h0300, 16'h0300);
        idle(3);
    endtask

    // Random windows checked against an independent behavioural model.
    task automatic test_random();
        logic [1:0]         wm;
        logic [15:0]        a, b, ex;
        logic signed [15:0] as, bs;
        longint             p, acc, sh;
        int                 len;
        for (int w = 0; w < 12; w++) begin
            wm  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 4);
            acc = 0;
            for (int i = 0; i < len; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                as = a;
                bs = b;
                if (wm == MAXP || wm == SUMM)
                    p = longint'(as) * 256;
                else
                    p = longint'(as) * longint'(bs);
                if (i == 0)
                    acc = p;
                else if (wm == MAXP)
                    acc = (p > acc) ? p : acc;
                else
                    acc = acc + p;
                sh = acc >>> 8;
`ifdef PE_SATURATE_EN
                if (sh > 32767) sh = 32767;
                else if (sh < -32768) sh = -32768;
`endif
                ex = sh[15:0];
                drive(1, i == 0, i == len - 1, (i == 0) ? wm : 2'($urandom_range(0, 3)), a, b, ex);
                if ($urandom_range(0, 2) == 0) bubble();
            end
        end
        idle(4);
    endtask

    initial begin
        vld = 1'b0; clr = 1'b0; last = 1'b0; mode = CONV; srca = '0; srcb = '0;
        test_reset();
        test_no_clr();
        test_conv();
        test_maxpool();
        test_bubbles();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
